// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: controller state encoding and
// the counter-width helper.
package debounce_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Wide enough to hold 0..stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Plain N-flop synchronizer for an asynchronous single-bit input; no logic
// between stages so metastability has a full cycle per stage to resolve.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronizes a raw input, requires it to differ from the
// current level for STABLE_CYCLES consecutive cycles, then commits the new
// level together with a one-cycle rise or fall pulse.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic settling
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             commit;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s != dout_q) begin
          // A single-cycle requirement means the first differing sample commits.
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_SETTLE: begin
        if (s == dout_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      dout_d  = s;
      rise_d  = s;
      fall_d  = ~s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign settling = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: a default instance and a STABLE_CYCLES=1 /
// SYNC_STAGES=3 instance driven from the same stimulus, scoreboarded per cycle.
module tb_debounce_edge;

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
    logic settling;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout0, rise0, fall0, settling0;
  logic dout1, rise1, fall1, settling1;

  always #5 clk = ~clk;

  debounce_edge #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16)
  ) u_dut0 (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .dout    (dout0),
    .rise    (rise0),
    .fall    (fall0),
    .settling(settling0)
  );

  debounce_edge #(
    .SYNC_STAGES  (3),
    .STABLE_CYCLES(1)
  ) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .dout    (dout1),
    .rise    (rise1),
    .fall    (fall1),
    .settling(settling1)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state, indexed by instance
  logic m_sync [2][4];
  logic m_dout [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run  [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_rise0, n_fall0, n_dout0_hi, rise0_edge, fall0_edge;
  int rise1_edge, n_settle1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Spec-level behaviour: count consecutive edges at which the synchronized
  // sample differs from the level; commit when the run reaches N.
  task automatic model_edge(input int id, input int S, input int N);
    logic s_old;
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_sync[id][i] = 1'b0;
      m_dout[id] = 1'b0;
      m_rise[id] = 1'b0;
      m_fall[id] = 1'b0;
      m_run[id]  = 0;
    end else begin
      s_old = m_sync[id][S-1];
      for (int i = S - 1; i > 0; i--) m_sync[id][i] = m_sync[id][i-1];
      m_sync[id][0] = din;
      m_rise[id] = 1'b0;
      m_fall[id] = 1'b0;
      if (s_old != m_dout[id]) begin
        m_run[id]++;
        if (m_run[id] == N) begin
          m_dout[id] = s_old;
          m_rise[id] = s_old;
          m_fall[id] = ~s_old;
          m_run[id]  = 0;
        end
      end else begin
        m_run[id] = 0;
      end
    end
    e.dout     = m_dout[id];
    e.rise     = m_rise[id];
    e.fall     = m_fall[id];
    e.settling = (m_run[id] != 0);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic step(input logic d, input logic r);
    exp_t e;
    din   = d;
    reset = r;
    @(posedge clk);
    cyc++;
    model_edge(0, 2, 16);
    model_edge(1, 3, 1);
    #1;
    chk("sb0_depth", 32'(q0.size() > 0), 32'd1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb0_outputs", {28'd0, dout0, rise0, fall0, settling0}, {28'd0, e});
    end
    chk("sb1_depth", 32'(q1.size() > 0), 32'd1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb1_outputs", {28'd0, dout1, rise1, fall1, settling1}, {28'd0, e});
    end
    if (rise0 === 1'b1) begin n_rise0++; rise0_edge = cyc; end
    if (fall0 === 1'b1) begin n_fall0++; fall0_edge = cyc; end
    if (dout0 === 1'b1) n_dout0_hi++;
    if (rise1 === 1'b1) rise1_edge = cyc;
    if (settling1 !== 1'b0) n_settle1++;
  endtask

  task automatic run(input logic d, input logic r, input int n);
    for (int i = 0; i < n; i++) step(d, r);
  endtask

  task automatic clr();
    n_rise0    = 0;
    n_fall0    = 0;
    n_dout0_hi = 0;
    rise0_edge = -1;
    fall0_edge = -1;
    rise1_edge = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, k2;
    n_settle1 = 0;
    din   = 1'b1;
    reset = 1'b1;
    clr();

    // Reset hold with din high, then release: rise after full latency
    run(1'b1, 1'b1, 3);
    chk("reset_dout", {31'd0, dout0}, 32'd0);
    clr();
    k = cyc + 1;
    run(1'b1, 1'b0, 25);
    chk("rel_rise_edge", rise0_edge, k + 17);
    chk("rel_rise_count", n_rise0, 1);
    chk("rel_dout", {31'd0, dout0}, 32'd1);
    chk("rel_corner_edge", rise1_edge, k + 3);

    // Clean press and release
    run(1'b0, 1'b0, 25);
    clr();
    k = cyc + 1;
    run(1'b1, 1'b0, 40);
    k2 = cyc + 1;
    run(1'b0, 1'b0, 25);
    chk("clean_rise_edge", rise0_edge, k + 17);
    chk("clean_fall_edge", fall0_edge, k2 + 17);
    chk("clean_rise_count", n_rise0, 1);
    chk("clean_fall_count", n_fall0, 1);
    chk("clean_dout_width", n_dout0_hi, 40);
    chk("corner_rise_edge", rise1_edge, k + 3);

    // Bounce 1,0,1,0 every 3 cycles, then settle high
    clr();
    for (int i = 0; i < 2; i++) begin
      run(1'b1, 1'b0, 3);
      run(1'b0, 1'b0, 3);
    end
    chk("bounce_no_dout", n_dout0_hi, 0);
    k = cyc + 1;
    run(1'b1, 1'b0, 25);
    chk("bounce_rise_count", n_rise0, 1);
    chk("bounce_rise_edge", rise0_edge, k + 17);

    // Boundary: 15 synchronized cycles rejected, 16 accepted
    run(1'b0, 1'b0, 30);
    clr();
    run(1'b1, 1'b0, 15);
    run(1'b0, 1'b0, 20);
    chk("bound15_no_rise", n_rise0, 0);
    k = cyc + 1;
    run(1'b1, 1'b0, 16);
    run(1'b0, 1'b0, 4);
    chk("bound16_rise_count", n_rise0, 1);
    chk("bound16_rise_edge", rise0_edge, k + 17);
    run(1'b0, 1'b0, 25);

    // Reset mid-settle discards the pending change
    clr();
    run(1'b1, 1'b0, 10);
    run(1'b1, 1'b1, 1);
    k = cyc + 1;
    run(1'b1, 1'b0, 25);
    chk("midrst_rise_count", n_rise0, 1);
    chk("midrst_rise_edge", rise0_edge, k + 17);

    chk("corner_never_settling", n_settle1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
